// File: rtl/micro_tile_pkg.sv
// Shared types and helpers for the micro-tile switch: switch-sequencer states
// and the sizing function for its cycle counters.
package micro_tile_pkg;

    typedef enum logic [1:0] {
        RESET_T = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2
    } tile_state_t;

    // Bits needed to hold a count from 0 up to and including max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/micro_tile_switch_if.sv
// Pin-side and tile-side bundle of the micro-tile switch; the switch is the
// slave, the pad ring plus hosted tiles form the master.
interface micro_tile_switch_if #(
    parameter int N_TILES = 4,
    parameter int SEL_W   = 4
);
    logic                   ext_rst_n;
    logic [SEL_W-1:0]       sel_in;
    logic [7:0]             ui_in;
    logic [7:0]             uo_out;
    logic [N_TILES*8-1:0]   tile_ui;
    logic [N_TILES*8-1:0]   tile_uo;
    logic [N_TILES-1:0]     tile_clk_en;
    logic [N_TILES-1:0]     tile_rst_n;
    logic [SEL_W-1:0]       active_sel;
    logic                   busy;

    modport slave (
        input  ext_rst_n, sel_in, ui_in, tile_uo,
        output uo_out, tile_ui, tile_clk_en, tile_rst_n, active_sel, busy
    );

    modport master (
        output ext_rst_n, sel_in, ui_in, tile_uo,
        input  uo_out, tile_ui, tile_clk_en, tile_rst_n, active_sel, busy
    );
endinterface

// File: rtl/micro_tile_sel_sync.sv
// Two-flop synchroniser and debouncer for the asynchronous tile-select pins;
// stable_sel only ever holds an in-range tile index.
module micro_tile_sel_sync
    import micro_tile_pkg::*;
#(
    parameter int N_TILES       = 4,
    parameter int SEL_W         = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] sel_in,
    output logic [SEL_W-1:0] stable_sel
);

    localparam int CW = cnt_width(STABLE_CYCLES);

    logic [SEL_W-1:0] meta_q;
    logic [SEL_W-1:0] sync_q;
    logic [CW-1:0]    stab_cnt_q;
    logic [CW-1:0]    stab_cnt_d;
    logic             in_range;

    // meta_q is the newest synchronised sample, sync_q the one before it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        stab_cnt_d = '0;
        if (meta_q == sync_q) begin
            stab_cnt_d = (stab_cnt_q == CW'(STABLE_CYCLES)) ? stab_cnt_q
                                                            : stab_cnt_q + CW'(1);
        end
    end

    assign in_range = (int'(sync_q) < N_TILES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q     <= '0;
            sync_q     <= '0;
            stab_cnt_q <= '0;
            stable_sel <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
            meta_q     <= sel_in;
            sync_q     <= meta_q;
            stab_cnt_q <= stab_cnt_d;
            if (stab_cnt_d == CW'(STABLE_CYCLES) && in_range) begin
                stable_sel <= sync_q;
            end
        end
    end

endmodule

// File: rtl/micro_tile_switch.sv
// Hosts N_TILES micro tiles behind one 8-in/8-out pin set and sequences tile
// switches as drain old tile -> clocked reset of new tile -> run.
module micro_tile_switch
    import micro_tile_pkg::*;
#(
    parameter int N_TILES       = 4,
    parameter int SEL_W         = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int DRAIN_CYCLES  = 2,
    parameter int RST_CYCLES    = 4
) (
    input  logic                clk,
    input  logic                rst,
    micro_tile_switch_if.slave  bus
);

    localparam int CW = cnt_width(max2(DRAIN_CYCLES, RST_CYCLES));

    tile_state_t          state_q;
    tile_state_t          state_d;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [SEL_W-1:0]     active_q;
    logic [SEL_W-1:0]     active_d;
    logic [SEL_W-1:0]     stable_sel;
    logic [7:0]           uo_q;
    logic [7:0]           active_uo;
    logic [N_TILES*8-1:0] tile_ui_c;
    logic [N_TILES-1:0]   tile_clk_en_c;
    logic [N_TILES-1:0]   tile_rst_n_c;
    int                   act_idx;

    micro_tile_sel_sync #(
        .N_TILES       (N_TILES),
        .SEL_W         (SEL_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_sel_sync (
        .clk        (clk),
        .rst        (rst),
        .sel_in     (bus.sel_in),
        .stable_sel (stable_sel)
    );

    assign act_idx   = int'(active_q);
    assign active_uo = bus.tile_uo[act_idx*8 +: 8];

    // Next-state logic; the shared counter restarts at zero on every state entry.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        active_d = active_q;
        unique case (state_q)
            RESET_T: begin
                if (cnt_q == CW'(RST_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (stable_sel != active_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q == CW'(DRAIN_CYCLES - 1)) begin
                    state_d  = RESET_T;
                    cnt_d    = '0;
                    active_d = stable_sel;
                end
            end
            default: begin
                state_d = RESET_T;
                cnt_d   = '0;
            end
        endcase
    end

    // Per-tile fan-out: only the owned tile is ever clocked, released or fed.
    always_comb begin
        tile_ui_c     = '0;
        tile_clk_en_c = '0;
        tile_rst_n_c  = '0;
        unique case (state_q)
            RESET_T: begin
                tile_clk_en_c[act_idx]     = 1'b1;
                tile_ui_c[act_idx*8 +: 8]  = bus.ui_in;
            end
            RUN: begin
                tile_clk_en_c[act_idx]     = 1'b1;
                tile_rst_n_c[act_idx]      = bus.ext_rst_n;
                tile_ui_c[act_idx*8 +: 8]  = bus.ui_in;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RESET_T;
            cnt_q    <= '0;
            active_q <= '0;
            uo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            // Capture only while staying in RUN, so the first RUN cycle and any switch show zero.
            uo_q     <= (state_q == RUN && state_d == RUN) ? active_uo : 8'h00;
        end
    end

    assign bus.uo_out      = uo_q;
    assign bus.tile_ui     = tile_ui_c;
    assign bus.tile_clk_en = tile_clk_en_c;
    assign bus.tile_rst_n  = tile_rst_n_c;
    assign bus.active_sel  = active_q;
    assign bus.busy        = (state_q != RUN);

endmodule

// File: tb/tb_micro_tile_switch.sv
// Directed bench for micro_tile_switch with default parameters: reset
// sequence, switching, debouncing, out-of-range select and reset mid-switch.
module tb_micro_tile_switch;

    localparam int N_TILES = 4;
    localparam int SEL_W   = 4;
    localparam logic [31:0] TILE_UO = {8'h3C, 8'hC3, 8'h11, 8'h5A};
    localparam logic [7:0]  UI_VAL  = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic busy_seen;

    micro_tile_switch_if #(.N_TILES(N_TILES), .SEL_W(SEL_W)) bus ();

    micro_tile_switch #(
        .N_TILES       (N_TILES),
        .SEL_W         (SEL_W),
        .STABLE_CYCLES (4),
        .DRAIN_CYCLES  (2),
        .RST_CYCLES    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_ui(input int k);
        logic [31:0] v;
        v = 32'(UI_VAL);
        return v << (8 * k);
    endfunction

    task automatic wait_run(input logic [SEL_W-1:0] exp, input int budget);
        int n;
        n = 0;
        while (n < budget && !(bus.busy === 1'b0 && bus.active_sel === exp)) begin
            step(1);
            n++;
        end
        check("wait_run_busy", 32'(bus.busy), 32'(0));
        check("wait_run_active", 32'(bus.active_sel), 32'(exp));
    endtask

    task automatic watch_busy(input int n);
        busy_seen = 1'b0;
        repeat (n) begin
            step(1);
            if (bus.busy !== 1'b0) busy_seen = 1'b1;
        end
    endtask

    initial begin
        bus.sel_in    = '0;
        bus.ui_in     = UI_VAL;
        bus.ext_rst_n = 1'b1;
        bus.tile_uo   = TILE_UO;
        step(3);

        // Values while reset is held
        check("rst_busy",    32'(bus.busy),        32'(1));
        check("rst_clk_en",  32'(bus.tile_clk_en), 32'(4'b0001));
        check("rst_rst_n",   32'(bus.tile_rst_n),  32'(4'b0000));
        check("rst_uo",      32'(bus.uo_out),      32'(0));
        check("rst_active",  32'(bus.active_sel),  32'(0));
        check("rst_tile_ui", bus.tile_ui,          exp_ui(0));

        // Release: four RESET_T cycles of tile 0, then RUN
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) step(1);
            check("rel_busy",   32'(bus.busy),        32'(1));
            check("rel_clk_en", 32'(bus.tile_clk_en), 32'(4'b0001));
            check("rel_rst_n",  32'(bus.tile_rst_n),  32'(4'b0000));
        end
        step(1);
        check("run0_busy",  32'(bus.busy),       32'(0));
        check("run0_rst_n", 32'(bus.tile_rst_n), 32'(4'b0001));
        check("run0_uo_lat", 32'(bus.uo_out),    32'(0));
        step(1);
        check("run0_uo", 32'(bus.uo_out), 32'(8'h5A));

        // ext_rst_n only touches the active tile's reset
        bus.ext_rst_n = 1'b0;
        #1;
        check("ext_rst_low",  32'(bus.tile_rst_n), 32'(4'b0000));
        check("ext_rst_busy", 32'(bus.busy),       32'(0));
        bus.ext_rst_n = 1'b1;
        #1;
        check("ext_rst_high", 32'(bus.tile_rst_n), 32'(4'b0001));

        // 3-cycle glitch to 1 is filtered
        bus.sel_in = 4'd1;
        step(3);
        bus.sel_in = 4'd0;
        watch_busy(14);
        check("glitch_busy",   32'(busy_seen),      32'(0));
        check("glitch_active", 32'(bus.active_sel), 32'(0));

        // Out-of-range select is ignored
        bus.sel_in = 4'd7;
        watch_busy(14);
        check("oor_busy",   32'(busy_seen),      32'(0));
        check("oor_active", 32'(bus.active_sel), 32'(0));
        check("oor_uo",     32'(bus.uo_out),     32'(8'h5A));
        bus.sel_in = 4'd0;
        step(8);

        // Switch 0 -> 2: DRAIN entered 7 cycles after the pin change
        bus.sel_in = 4'd2;
        step(6);
        check("sw2_pre_busy", 32'(bus.busy), 32'(0));
        step(1);
        check("sw2_drain_busy",   32'(bus.busy),        32'(1));
        check("sw2_drain_clk_en", 32'(bus.tile_clk_en), 32'(0));
        check("sw2_drain_rst_n",  32'(bus.tile_rst_n),  32'(0));
        check("sw2_drain_ui",     bus.tile_ui,          32'(0));
        check("sw2_drain_uo",     32'(bus.uo_out),      32'(0));
        check("sw2_drain_active", 32'(bus.active_sel),  32'(0));
        step(1);
        check("sw2_drain2_busy",   32'(bus.busy),        32'(1));
        check("sw2_drain2_clk_en", 32'(bus.tile_clk_en), 32'(0));
        step(1);
        check("sw2_rt_active", 32'(bus.active_sel),  32'(2));
        check("sw2_rt_clk_en", 32'(bus.tile_clk_en), 32'(4'b0100));
        check("sw2_rt_rst_n",  32'(bus.tile_rst_n),  32'(0));
        check("sw2_rt_ui",     bus.tile_ui,          exp_ui(2));
        step(3);
        check("sw2_rt_last_busy", 32'(bus.busy), 32'(1));
        step(1);
        check("sw2_run_busy",  32'(bus.busy),       32'(0));
        check("sw2_run_uo0",   32'(bus.uo_out),     32'(0));
        check("sw2_run_rst_n", 32'(bus.tile_rst_n), 32'(4'b0100));
        step(1);
        check("sw2_run_uo", 32'(bus.uo_out), 32'(8'hC3));

        // rst pulsed during DRAIN of a 1 -> 2 switch
        bus.sel_in = 4'd1;
        wait_run(4'd1, 40);
        bus.sel_in = 4'd2;
        step(7);
        check("rsw_drain_busy", 32'(bus.busy), 32'(1));
        rst = 1'b1;
        #1;
        check("rsw_busy",   32'(bus.busy),        32'(1));
        check("rsw_active", 32'(bus.active_sel),  32'(0));
        check("rsw_clk_en", 32'(bus.tile_clk_en), 32'(4'b0001));
        check("rsw_rst_n",  32'(bus.tile_rst_n),  32'(0));
        check("rsw_uo",     32'(bus.uo_out),      32'(0));
        step(1);
        rst = 1'b0;
        step(4);
        check("rsw_run0_busy",   32'(bus.busy),       32'(0));
        check("rsw_run0_active", 32'(bus.active_sel), 32'(0));
        step(1);
        check("rsw_run0_uo", 32'(bus.uo_out), 32'(8'h5A));
        wait_run(4'd2, 40);
        step(1);
        check("rsw_run2_uo", 32'(bus.uo_out), 32'(8'hC3));

        // Back to 0, then 0 -> 1 with a change to 3 landing during RESET_T
        bus.sel_in = 4'd0;
        wait_run(4'd0, 40);
        bus.sel_in = 4'd1;
        step(5);
        bus.sel_in = 4'd3;
        step(1);
        check("dbl_pre_busy", 32'(bus.busy), 32'(0));
        step(1);
        check("dbl_drain1_busy", 32'(bus.busy), 32'(1));
        step(2);
        check("dbl_rt1_active", 32'(bus.active_sel),  32'(1));
        check("dbl_rt1_clk_en", 32'(bus.tile_clk_en), 32'(4'b0010));
        step(4);
        check("dbl_run1_busy",   32'(bus.busy),       32'(0));
        check("dbl_run1_active", 32'(bus.active_sel), 32'(1));
        step(1);
        check("dbl_drain2_busy",   32'(bus.busy),       32'(1));
        check("dbl_drain2_active", 32'(bus.active_sel), 32'(1));
        step(2);
        check("dbl_rt3_active", 32'(bus.active_sel), 32'(3));
        check("dbl_rt3_busy",   32'(bus.busy),       32'(1));
        step(4);
        check("dbl_run3_busy", 32'(bus.busy), 32'(0));
        step(1);
        check("dbl_run3_uo", 32'(bus.uo_out), 32'(8'h3C));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
